// File: rtl/sprite_ctrl_pkg.sv
// Shared FSM encoding, config field selectors and power-on sprite defaults
// for the sprite motion scheduler.
package sprite_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] SEL_X     = 3'd0;
   localparam logic [2:0] SEL_Y     = 3'd1;
   localparam logic [2:0] SEL_X_MIN = 3'd2;
   localparam logic [2:0] SEL_X_MAX = 3'd3;
   localparam logic [2:0] SEL_SPEED = 3'd4;

   localparam logic [15:0] X_RST     = 16'd500;
   localparam logic [15:0] Y_RST     = 16'd150;
   localparam logic [15:0] X_MIN_RST = 16'd300;
   localparam logic [15:0] X_MAX_RST = 16'd1000;
   localparam logic [15:0] SPEED_RST = 16'd5;

endpackage

// File: rtl/sprite_motion_step.sv
// One horizontal motion step: move by speed, clamp into [x_min, x_max],
// and bounce direction/flip at the limits.
module sprite_motion_step #(
   parameter int SPEED_W = 4
) (
   input  logic [15:0]        x,
   input  logic [15:0]        x_min,
   input  logic [15:0]        x_max,
   input  logic [SPEED_W-1:0] speed,
   input  logic               dir,
   input  logic               flip,
   output logic [15:0]        x_next,
   output logic               dir_next,
   output logic               flip_next
);

   logic [16:0] raw;

   always_comb begin
      raw       = dir ? ({1'b0, x} + 17'(speed)) : ({1'b0, x} - 17'(speed));
      x_next    = x;
      dir_next  = dir;
      flip_next = flip;
      if (x_min >= x_max) begin
         x_next = x_min;
      end else begin
         // bit 16 on a leftward step is a borrow, i.e. the sprite went below zero
         if (!dir && raw[16])
            x_next = x_min;
         else if (raw > {1'b0, x_max})
            x_next = x_max;
         else if (raw < {1'b0, x_min})
            x_next = x_min;
         else
            x_next = raw[15:0];

         if (dir && x_next >= x_max) begin
            dir_next  = 1'b0;
            flip_next = 1'b1;
         end else if (!dir && x_next <= x_min) begin
            dir_next  = 1'b1;
            flip_next = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sprite_motion_scheduler.sv
// Per-frame sprite mover: on each v_sync rising edge, steps every sprite once,
// one per clock, through a single shared step unit.
module sprite_motion_scheduler
   import sprite_ctrl_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int SPEED_W     = 4
) (
   input  logic                                                 i_clk,
   input  logic                                                 i_rst_n,
   input  logic                                                 i_v_sync,
   input  logic                                                 i_enable,
   input  logic                                                 i_cfg_we,
   input  logic [(NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1)-1:0] i_cfg_idx,
   input  logic [2:0]                                           i_cfg_sel,
   input  logic [15:0]                                          i_cfg_data,
   output logic [16*NUM_SPRITES-1:0]                            o_sprite_x,
   output logic [16*NUM_SPRITES-1:0]                            o_sprite_y,
   output logic [NUM_SPRITES-1:0]                               o_flip,
   output logic                                                 o_busy,
   output logic                                                 o_frame_done,
   output logic                                                 o_missed_frame,
   output logic [7:0]                                           o_frame_cnt
);

   localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

   logic [NUM_SPRITES-1:0][15:0]        x_q, y_q, xmin_q, xmax_q;
   logic [NUM_SPRITES-1:0][SPEED_W-1:0] speed_q;
   logic [NUM_SPRITES-1:0]              dir_q, flip_q;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              v_sync_q, armed_q, sync_edge;
   logic              busy_d, done_d, missed_d;
   logic [15:0]       step_x;
   logic              step_dir, step_flip;

   // armed_q masks the first cycle after reset so a v_sync already high is not an edge
   assign sync_edge = i_v_sync & ~v_sync_q & armed_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      missed_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sync_edge && i_enable) begin
               state_d = ST_UPDATE;
               idx_d   = '0;
            end
         end
         ST_UPDATE: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
      if (sync_edge && state_q != ST_IDLE)
         missed_d = 1'b1;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         v_sync_q       <= 1'b0;
         armed_q        <= 1'b0;
         o_busy         <= 1'b0;
         o_frame_done   <= 1'b0;
         o_missed_frame <= 1'b0;
         o_frame_cnt    <= 8'd0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         v_sync_q       <= i_v_sync;
         armed_q        <= 1'b1;
         o_busy         <= busy_d;
         o_frame_done   <= done_d;
         o_missed_frame <= missed_d;
         if (done_d)
            o_frame_cnt <= o_frame_cnt + 8'd1;
      end
   end

   sprite_motion_step #(.SPEED_W(SPEED_W)) u_step (
      .x         (x_q[idx_q]),
      .x_min     (xmin_q[idx_q]),
      .x_max     (xmax_q[idx_q]),
      .speed     (speed_q[idx_q]),
      .dir       (dir_q[idx_q]),
      .flip      (flip_q[idx_q]),
      .x_next    (step_x),
      .dir_next  (step_dir),
      .flip_next (step_flip)
   );

   // config write is assigned after the step so a same-cycle write to a field wins
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < NUM_SPRITES; s++) begin
            x_q[s]     <= X_RST;
            y_q[s]     <= Y_RST;
            xmin_q[s]  <= X_MIN_RST;
            xmax_q[s]  <= X_MAX_RST;
            speed_q[s] <= SPEED_W'(SPEED_RST);
            dir_q[s]   <= 1'b1;
            flip_q[s]  <= 1'b0;
         end
      end else begin
         for (int s = 0; s < NUM_SPRITES; s++) begin
            if (state_q == ST_UPDATE && idx_q == IDX_W'(s)) begin
               x_q[s]    <= step_x;
               dir_q[s]  <= step_dir;
               flip_q[s] <= step_flip;
            end
            if (i_cfg_we && i_cfg_idx == IDX_W'(s)) begin
               case (i_cfg_sel)
                  SEL_X:     x_q[s]     <= i_cfg_data;
                  SEL_Y:     y_q[s]     <= i_cfg_data;
                  SEL_X_MIN: xmin_q[s]  <= i_cfg_data;
                  SEL_X_MAX: xmax_q[s]  <= i_cfg_data;
                  SEL_SPEED: speed_q[s] <= i_cfg_data[SPEED_W-1:0];
                  default: ;
               endcase
            end
         end
      end
   end

   assign o_sprite_x = x_q;
   assign o_sprite_y = y_q;
   assign o_flip     = flip_q;

endmodule

// File: doc/sprite_motion_scheduler.md
SPRITE_MOTION_SCHEDULER -- requirements
Module: sprite_motion_scheduler

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4, number of independently moving sprites (1..8).
REQ-002 SHALL have parameter SPEED_W, default 4, width of the per-sprite speed field.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port i_v_sync, input, 1, frame sync, already synchronous to i_clk.
REQ-006 SHALL have port i_enable, input, 1, motion enable; 0 freezes all positions.
REQ-007 SHALL have port i_cfg_we, input, 1, config write strobe.
REQ-008 SHALL have port i_cfg_idx, input, $clog2(NUM_SPRITES), target sprite.
REQ-009 SHALL have port i_cfg_sel, input, 3, field: 0 x, 1 y, 2 x_min, 3 x_max, 4 speed, others ignored.
REQ-010 SHALL have port i_cfg_data, input, 16, write data; speed uses bits [SPEED_W-1:0].
REQ-011 SHALL have port o_sprite_x, output, 16*NUM_SPRITES, packed x positions, sprite 0 in LSBs.
REQ-012 SHALL have port o_sprite_y, output, 16*NUM_SPRITES, packed y positions.
REQ-013 SHALL have port o_flip, output, NUM_SPRITES, horizontal flip per sprite.
REQ-014 SHALL have ports o_busy (1), o_frame_done (1, pulse), o_missed_frame (1, pulse), o_frame_cnt (8).

Function
REQ-015 SHALL register i_v_sync and detect a rising edge (current 1, registered 0).
REQ-016 SHALL implement FSM IDLE -> UPDATE -> DONE -> IDLE.
REQ-017 IDLE: edge with i_enable=1 SHALL enter UPDATE with index 0; edge with i_enable=0 SHALL be ignored.
REQ-018 UPDATE: one sprite per cycle, index 0..NUM_SPRITES-1; after last index SHALL enter DONE.
REQ-019 Step: x_next = dir ? x+speed : x-speed, computed 17-bit, then clamped to [x_min, x_max].
REQ-020 dir=1 and x_next>=x_max: dir<=0, flip<=1; dir=0 and x_next<=x_min: dir<=1, flip<=0.
REQ-021 If x_min>=x_max, x SHALL be forced to x_min, dir and flip unchanged.
REQ-022 y SHALL only change by config write.
REQ-023 DONE: o_frame_done=1 for exactly one cycle, o_frame_cnt increments (wraps 255->0), then IDLE.
REQ-024 Latency: edge detected at cycle n -> sprite k written at end of cycle n+1+k; o_frame_done high in cycle n+1+NUM_SPRITES.
REQ-025 o_busy SHALL be 1 in UPDATE and DONE, 0 in IDLE.
REQ-026 Edge while busy SHALL be dropped and o_missed_frame pulsed one cycle.
REQ-027 Config writes SHALL be accepted in any state, taking effect next cycle.
REQ-028 Write to the sprite being stepped in the same cycle: written field wins; unwritten fields take step result.
REQ-029 Writing x SHALL NOT change dir or flip; i_enable dropping mid-UPDATE SHALL NOT abort the sweep.
REQ-030 Outputs SHALL be direct register outputs (no combinational path from inputs).

Reset
REQ-031 On i_rst_n=0, immediately: state IDLE, index 0, sync register 0.
REQ-032 Per sprite: x=500, y=150, x_min=300, x_max=1000, speed=5, dir=1, flip=0.
REQ-033 o_busy=0, o_frame_done=0, o_missed_frame=0, o_frame_cnt=0.
REQ-034 Reset asserted mid-UPDATE SHALL discard the sweep; no o_frame_done follows.
REQ-035 An i_v_sync already high at reset release SHALL NOT count as an edge.

Structure
REQ-036 Package sprite_ctrl_pkg SHALL hold the FSM state enum, cfg_sel field codes and reset-default constants.
REQ-037 Combinational step/clamp/bounce logic SHALL be sub-module sprite_motion_step, instantiated once and time-shared across sprites.

Verification
REQ-038 Reset, one edge: sprite 0 x 500->505, dir=1; o_frame_done at n+5 with NUM_SPRITES=4.
REQ-039 x=998, speed 5, x_max 1000: x->1000, dir=0, flip=1; next frame x=995.
REQ-040 x=302, dir=0, speed 5: x->300, dir=1, flip=0.
REQ-041 Second edge 2 cycles after the first: o_missed_frame pulses; o_frame_cnt rises by 1 only.
REQ-042 Write x=700 to sprite 1 in its UPDATE cycle: x reads 700; dir unchanged.
REQ-043 i_rst_n low at UPDATE index 2: all defaults restored; o_frame_done never pulses.
